// File: rtl/sonar_sweep_controller_pkg.sv
// Shared constants for the sonar sweep controller: state codes, sweep and
// frame sizes, and the meaning of each frame character index.
package sonar_pkg;

    typedef logic [3:0] estado_t;

    localparam estado_t ST_INICIAL        = 4'd0;
    localparam estado_t ST_PREPARA        = 4'd1;
    localparam estado_t ST_POSICIONA      = 4'd2;
    localparam estado_t ST_MEDE           = 4'd3;
    localparam estado_t ST_AGUARDA_MEDIDA = 4'd4;
    localparam estado_t ST_TRANSMITE      = 4'd5;
    localparam estado_t ST_AGUARDA_TX     = 4'd6;
    localparam estado_t ST_PROX_CHAR      = 4'd7;
    localparam estado_t ST_PROX_POSICAO   = 4'd8;
    localparam estado_t ST_FALHA          = 4'd9;

    localparam int NUM_POSICOES = 8;
    localparam int NUM_CHARS    = 8;

    localparam logic [2:0] POS_MIN = 3'd0;
    localparam logic [2:0] POS_MAX = 3'(NUM_POSICOES - 1);

    // Frame layout: three angle digits, comma, three distance digits, period.
    localparam logic [2:0] CHAR_ANG0    = 3'd0;
    localparam logic [2:0] CHAR_ANG1    = 3'd1;
    localparam logic [2:0] CHAR_ANG2    = 3'd2;
    localparam logic [2:0] CHAR_VIRGULA = 3'd3;
    localparam logic [2:0] CHAR_DIST0   = 3'd4;
    localparam logic [2:0] CHAR_DIST1   = 3'd5;
    localparam logic [2:0] CHAR_DIST2   = 3'd6;
    localparam logic [2:0] CHAR_PONTO   = 3'(NUM_CHARS - 1);

endpackage

// File: rtl/sonar_sweep_controller_if.sv
// Signal bundle between the sweep controller (master) and the datapath /
// top-level enable (slave).
interface sonar_sweep_if;

    logic       ligar;
    logic       pronto_medida;
    logic       pronto_tx;
    logic       medir;
    logic       partida_tx;
    logic [2:0] seletor;
    logic [2:0] posicao;
    logic       fim_posicao;
    logic       erro_medida;
    logic [3:0] db_estado;

    // Handshakes are pulse based with no backpressure: medir/partida_tx are
    // one-cycle requests, pronto_medida/pronto_tx are one-cycle completions
    // that only count while the controller is waiting for them.
    modport master (
        input  ligar, pronto_medida, pronto_tx,
        output medir, partida_tx, seletor, posicao, fim_posicao, erro_medida, db_estado
    );

    modport slave (
        output ligar, pronto_medida, pronto_tx,
        input  medir, partida_tx, seletor, posicao, fim_posicao, erro_medida, db_estado
    );

endinterface

// File: rtl/sonar_sweep_controller_contador.sv
// Modulo-M up counter with synchronous clear and enable; it saturates at the
// terminal count instead of wrapping, and flags when it is there.
module contador_m #(
    parameter int M = 16,
    parameter int N = (M > 1) ? $clog2(M) : 1
) (
    input  logic clock,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic fim
);

    localparam logic [N-1:0] TERMINAL = N'(M - 1);

    logic [N-1:0] cnt_q;
    logic [N-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && (cnt_q != TERMINAL)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign fim = (cnt_q == TERMINAL);

endmodule

// File: rtl/sonar_sweep_controller.sv
// Sweep-measure-transmit sequencer: ping-pong servo sweep over 8 positions,
// one measurement per position and an 8-character frame per good measurement.
module sonar_sweep_controller
    import sonar_pkg::*;
#(
    parameter int TIMER   = 100_000_000,
    parameter int TIMEOUT = 1_250_000
) (
    input  logic          clock,
    input  logic          reset,
    sonar_sweep_if.master bus
);

    estado_t    estado_q, estado_d;
    logic [2:0] posicao_q, posicao_d;
    logic [2:0] seletor_q, seletor_d;
    logic       sobe_q, sobe_d;
    logic [2:0] pos_nova;

    logic timer_clr, timer_en, timer_fim;
    logic to_clr, to_en, to_fim;

    logic medir, partida_tx, fim_posicao, erro_medida;

    contador_m #(.M(TIMER)) u_timer (
        .clock (clock),
        .reset (reset),
        .clr   (timer_clr),
        .en    (timer_en),
        .fim   (timer_fim)
    );

    contador_m #(.M(TIMEOUT)) u_timeout (
        .clock (clock),
        .reset (reset),
        .clr   (to_clr),
        .en    (to_en),
        .fim   (to_fim)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            estado_q  <= ST_INICIAL;
            posicao_q <= '0;
            seletor_q <= '0;
            sobe_q    <= 1'b1;
        end else begin
            estado_q  <= estado_d;
            posicao_q <= posicao_d;
            seletor_q <= seletor_d;
            sobe_q    <= sobe_d;
        end
    end

    always_comb begin
        estado_d = ST_INICIAL;
        case (estado_q)
            ST_INICIAL:        estado_d = bus.ligar ? ST_PREPARA : ST_INICIAL;
            ST_PREPARA:        estado_d = ST_POSICIONA;
            ST_POSICIONA:      estado_d = timer_fim ? ST_MEDE : ST_POSICIONA;
            ST_MEDE:           estado_d = ST_AGUARDA_MEDIDA;
            // A measurement landing on the timeout's last cycle still counts.
            ST_AGUARDA_MEDIDA: begin
                if (bus.pronto_medida) begin
                    estado_d = ST_TRANSMITE;
                end else if (to_fim) begin
                    estado_d = ST_FALHA;
                end else begin
                    estado_d = ST_AGUARDA_MEDIDA;
                end
            end
            ST_TRANSMITE:      estado_d = ST_AGUARDA_TX;
            ST_AGUARDA_TX: begin
                if (bus.pronto_tx) begin
                    estado_d = (seletor_q == CHAR_PONTO) ? ST_PROX_POSICAO : ST_PROX_CHAR;
                end else begin
                    estado_d = ST_AGUARDA_TX;
                end
            end
            ST_PROX_CHAR:      estado_d = ST_TRANSMITE;
            ST_FALHA:          estado_d = ST_PROX_POSICAO;
            ST_PROX_POSICAO:   estado_d = bus.ligar ? ST_POSICIONA : ST_INICIAL;
            default:           estado_d = ST_INICIAL;
        endcase
    end

    always_comb begin
        posicao_d   = posicao_q;
        seletor_d   = seletor_q;
        sobe_d      = sobe_q;
        timer_clr   = 1'b0;
        timer_en    = 1'b0;
        to_clr      = 1'b0;
        to_en       = 1'b0;
        medir       = 1'b0;
        partida_tx  = 1'b0;
        fim_posicao = 1'b0;
        erro_medida = 1'b0;
        pos_nova    = sobe_q ? (posicao_q + 3'd1) : (posicao_q - 3'd1);
        case (estado_q)
            ST_PREPARA: begin
                posicao_d = POS_MIN;
                seletor_d = CHAR_ANG0;
                sobe_d    = 1'b1;
                timer_clr = 1'b1;
            end
            ST_POSICIONA: timer_en = 1'b1;
            ST_MEDE: begin
                medir  = 1'b1;
                to_clr = 1'b1;
            end
            ST_AGUARDA_MEDIDA: begin
                to_en = 1'b1;
                if (bus.pronto_medida) begin
                    seletor_d = CHAR_ANG0;
                end
            end
            ST_TRANSMITE: partida_tx = 1'b1;
            ST_PROX_CHAR: seletor_d = seletor_q + 3'd1;
            ST_FALHA:     erro_medida = 1'b1;
            // Direction turns around as soon as an endpoint is reached.
            ST_PROX_POSICAO: begin
                posicao_d = pos_nova;
                timer_clr = 1'b1;
                if (pos_nova == POS_MAX) begin
                    sobe_d = 1'b0;
                end else if (pos_nova == POS_MIN) begin
                    sobe_d = 1'b1;
                end
                fim_posicao = (pos_nova == POS_MAX) || (pos_nova == POS_MIN);
            end
            default: ;
        endcase
    end

    assign bus.medir       = medir;
    assign bus.partida_tx  = partida_tx;
    assign bus.fim_posicao = fim_posicao;
    assign bus.erro_medida = erro_medida;
    assign bus.seletor     = seletor_q;
    assign bus.posicao     = posicao_q;
    assign bus.db_estado   = estado_q;

endmodule

// File: tb/tb_sonar_sweep_controller.sv
// Bench for sonar_sweep_controller: table-driven and random positions with
// measurement/UART responders, a frame scoreboard and a sweep reference model.
module tb_sonar_sweep_controller;
  import sonar_pkg::*;

  localparam int TIMER   = 250;
  localparam int TIMEOUT = 100;
  localparam int BUDGET  = 2000;

  logic clock;
  logic reset;
  sonar_sweep_if bus ();

  sonar_sweep_controller #(.TIMER(TIMER), .TIMEOUT(TIMEOUT)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  // clock / watchdog
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #900_000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1, "watchdog");
  end

  int n_checks;
  int n_fail;
  int k_pos;

  logic [2:0] exp_q[$];
  logic [2:0] got_q[$];

  int         r_medir_at, r_n_tx, r_n_err, r_err_lat, r_fim, r_bad_gap;
  bit         r_done;
  logic [2:0] r_pos_at_medir;
  logic [3:0] r_st1, r_st2;

  typedef struct {
    int md;         // cycles from medir to pronto_medida, -1 = never
    int txd;        // cycles from partida_tx to pronto_tx
    bit exp_frame;  // expected: full frame sent (else erro_medida)
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  // Reference sweep: visit n of a ping-pong over 0..7 has period 14.
  function automatic int seq_pos(input int n);
    int m;
    m = n % 14;
    return (m <= 7) ? m : 14 - m;
  endfunction

  function automatic bit frame_expected(input int md);
    return (md >= 1) && (md <= TIMEOUT);
  endfunction

  // Drives one position's worth of responses, sampling on negedges.
  task automatic run_position(input int md, input int txd, input int drop_sel, input int abort_sel);
    int tx_due, pm_cyc, ptx_cyc;
    r_done = 1'b0; r_medir_at = -1; r_n_tx = 0; r_n_err = 0; r_err_lat = -1;
    r_fim = 0; r_bad_gap = 0; r_pos_at_medir = 'x; r_st1 = 'x; r_st2 = 'x;
    tx_due = -1; pm_cyc = -100; ptx_cyc = -100;
    got_q.delete();
    for (int cyc = 1; cyc <= BUDGET && !r_done; cyc++) begin
      @(negedge clock);
      bus.pronto_medida = 1'b0;
      bus.pronto_tx     = 1'b0;
      if (cyc == 1) r_st1 = bus.db_estado;
      if (cyc == 2) r_st2 = bus.db_estado;
      if (bus.medir) begin
        r_medir_at     = cyc;
        r_pos_at_medir = bus.posicao;
      end
      if (bus.partida_tx) begin
        r_n_tx++;
        got_q.push_back(bus.seletor);
        tx_due = cyc + txd;
        if ((r_n_tx == 1) ? (cyc != pm_cyc + 1) : (cyc != ptx_cyc + 2)) r_bad_gap++;
      end
      if (bus.erro_medida) begin
        r_n_err++;
        r_err_lat = cyc - r_medir_at;
      end
      if (bus.fim_posicao) r_fim++;
      if (bus.db_estado == ST_PROX_POSICAO) r_done = 1'b1;
      // stray completions during the dwell must be ignored
      if (cyc == 5) begin
        bus.pronto_medida = 1'b1;
        bus.pronto_tx     = 1'b1;
      end
      if (md >= 0 && r_medir_at >= 0 && cyc == r_medir_at + md) begin
        bus.pronto_medida = 1'b1;
        pm_cyc = cyc;
      end
      if (cyc == tx_due) begin
        bus.pronto_tx = 1'b1;
        ptx_cyc = cyc;
      end
      if (drop_sel >= 0 && bus.db_estado == ST_AGUARDA_TX && bus.seletor == 3'(drop_sel))
        bus.ligar = 1'b0;
      if (abort_sel >= 0 && bus.db_estado == ST_AGUARDA_TX && bus.seletor == 3'(abort_sel)) begin
        reset  = 1'b1;
        r_done = 1'b1;
      end
    end
  endtask

  task automatic do_position(input int md, input int txd, input bit exp_frame,
                             input bit from_idle, input int drop_sel);
    int exp_now, exp_next;
    exp_now  = seq_pos(k_pos);
    exp_next = seq_pos(k_pos + 1);
    exp_q.delete();
    if (exp_frame) for (int c = 0; c < NUM_CHARS; c++) exp_q.push_back(3'(c));
    run_position(md, txd, drop_sel, -1);
    check("position_done", 32'(r_done), 1);
    if (from_idle) begin
      check("state_prepara", 32'(r_st1), 32'(ST_PREPARA));
      check("state_posiciona", 32'(r_st2), 32'(ST_POSICIONA));
    end
    // from idle, medir lands in the 253rd cycle counting the ligar cycle as the first
    check("medir_latency", r_medir_at, from_idle ? (1 + 1 + TIMER + 1) - 1 : TIMER);
    check("posicao_dwell", 32'(r_pos_at_medir), exp_now);
    check("partida_count", r_n_tx, exp_frame ? NUM_CHARS : 0);
    check("frame_length", got_q.size(), exp_q.size());
    while (got_q.size() > 0 && exp_q.size() > 0)
      check("seletor_order", 32'(got_q.pop_front()), 32'(exp_q.pop_front()));
    check("erro_count", r_n_err, exp_frame ? 0 : 1);
    if (!exp_frame) check("erro_latency", r_err_lat, TIMEOUT + 1);
    check("tx_gaps", r_bad_gap, 0);
    check("fim_posicao", r_fim, (exp_next == 0 || exp_next == 7) ? 1 : 0);
    @(negedge clock);
    check("posicao_next", 32'(bus.posicao), exp_next);
    check("state_after", 32'(bus.db_estado), bus.ligar ? 32'(ST_POSICIONA) : 32'(ST_INICIAL));
    k_pos++;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_medir"},       32'(bus.medir), 0);
    check({tag, "_partida_tx"},  32'(bus.partida_tx), 0);
    check({tag, "_seletor"},     32'(bus.seletor), 0);
    check({tag, "_posicao"},     32'(bus.posicao), 0);
    check({tag, "_fim_posicao"}, 32'(bus.fim_posicao), 0);
    check({tag, "_erro_medida"}, 32'(bus.erro_medida), 0);
    check({tag, "_db_estado"},   32'(bus.db_estado), 32'(ST_INICIAL));
  endtask

  initial begin
    int md, txd;
    n_checks = 0;
    n_fail   = 0;
    k_pos    = 0;
    vecs[0] = '{20, 10, 1'b1};    // nominal frame
    vecs[1] = '{100, 10, 1'b1};   // measurement on the timeout's terminal cycle
    vecs[2] = '{-1, 10, 1'b0};    // no measurement at all
    vecs[3] = '{101, 10, 1'b0};   // measurement one cycle too late
    vecs[4] = '{1, 3, 1'b1};      // earliest possible measurement
    vecs[5] = '{55, 1, 1'b1};     // UART answering immediately

    reset = 1'b1;
    bus.ligar = 1'b0;
    bus.pronto_medida = 1'b0;
    bus.pronto_tx = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check_all_zero("reset");
    reset = 1'b0;
    repeat (4) @(negedge clock);
    check("idle_without_ligar", 32'(bus.db_estado), 32'(ST_INICIAL));

    bus.ligar = 1'b1;
    check("state_at_ligar", 32'(bus.db_estado), 32'(ST_INICIAL));
    for (int i = 0; i < 6; i++)
      do_position(vecs[i].md, vecs[i].txd, vecs[i].exp_frame, i == 0, -1);

    for (int i = 6; i < 16; i++) begin
      md  = ($urandom_range(0, 3) == 0) ? -1 : int'($urandom_range(1, TIMEOUT + 20));
      txd = int'($urandom_range(1, 12));
      do_position(md, txd, frame_expected(md), 1'b0, -1);
    end
    check("posicao_after_16", 32'(bus.posicao), seq_pos(16));

    // ligar dropped mid-frame: frame completes, then idle
    do_position(30, 4, 1'b1, 1'b0, 3);
    repeat (10) @(negedge clock);
    check("stays_idle", 32'(bus.db_estado), 32'(ST_INICIAL));
    check("no_medir_idle", 32'(bus.medir), 0);

    // restart sweeps from position 0 upward
    k_pos = 0;
    bus.ligar = 1'b1;
    do_position(15, 5, 1'b1, 1'b1, -1);

    // reset in the middle of a frame
    run_position(25, 6, -1, 5);
    bus.pronto_medida = 1'b0;
    bus.pronto_tx = 1'b0;
    check("abort_reached", 32'(r_done), 1);
    check("abort_partidas", r_n_tx, 6);
    @(negedge clock);
    check_all_zero("abort");
    reset = 1'b0;
    bus.ligar = 1'b0;
    @(negedge clock);
    check("post_abort_idle", 32'(bus.db_estado), 32'(ST_INICIAL));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sonar_sweep_controller.md
# sonar_sweep_controller

Control unit for the sonar's sweep–measure–transmit cycle. It steps the servo through 8 positions in a ping-pong sweep, waits a dwell time at each one, requests one ultrasonic measurement, and then sequences an 8-character serial frame (angle, distance). It sits between the top-level `ligar` input and the datapath blocks: the measurement interface, the servo PWM generator, the UART transmitter and its character mux.

## Interface
Parameters:
- `TIMER`, default 100_000_000: dwell cycles per position, covering servo settle plus inter-measurement delay (2 s at 50 MHz).
- `TIMEOUT`, default 1_250_000: maximum cycles to wait for `pronto_medida` (25 ms).

Ports:
- `clock`  in  1: system clock, single domain.
- `reset`  in  1: synchronous, active-high.
- `ligar`  in  1: level enable for sweeping.
- `pronto_medida`  in  1: one-cycle pulse from the measurement interface when a distance is valid.
- `pronto_tx`  in  1: one-cycle pulse from the UART when a character has finished.
- `medir`  out  1: one-cycle request to start a measurement.
- `partida_tx`  out  1: one-cycle request to send the character selected by `seletor`.
- `seletor`  out  3: frame character index, 0..7.
- `posicao`  out  3: servo position index, 0..7.
- `fim_posicao`  out  1: one-cycle pulse when the sweep reaches an endpoint.
- `erro_medida`  out  1: one-cycle pulse on measurement timeout.
- `db_estado`  out  4: current state code.

All outputs are 0 in reset.

## Operation
States and codes:
- INICIAL (0): idle, all strobes low. Goes to PREPARA when `ligar`=1.
- PREPARA (1): sets `posicao`=0, direction=up, clears `seletor` and the timer. Goes to POSICIONA.
- POSICIONA (2): timer increments each cycle. Goes to MEDE when timer = TIMER-1.
- MEDE (3): `medir`=1 for this cycle; clears the timeout counter. Goes to AGUARDA_MEDIDA.
- AGUARDA_MEDIDA (4): if `pronto_medida`, clears `seletor` and goes to TRANSMITE. Otherwise, if timeout count = TIMEOUT-1, goes to FALHA. If both occur in the same cycle, `pronto_medida` wins.
- TRANSMITE (5): `partida_tx`=1 for this cycle. Goes to AGUARDA_TX.
- AGUARDA_TX (6): on `pronto_tx`, goes to PROX_POSICAO if `seletor`=7, else to PROX_CHAR.
- PROX_CHAR (7): `seletor`+1. Goes to TRANSMITE.
- FALHA (9): `erro_medida`=1 for this cycle; no frame is sent. Goes to PROX_POSICAO.
- PROX_POSICAO (8): advances the position (rules below) and clears the timer. Goes to INICIAL if `ligar`=0, else to POSICIONA.
- Codes 10–15 are unused; they recover to INICIAL on the next clock.

Position rules:
- Ping-pong sequence is 0,1,…,7,6,…,0,1,…. Direction flips when the new position is 7 (up→down) or 0 (down→up).
- `fim_posicao` pulses in PROX_POSICAO when the new `posicao` is 0 or 7.

Transfer and enable rules:
- `ligar` is sampled only in INICIAL and PROX_POSICAO. Dropping it mid-cycle lets the current frame complete.
- `pronto_tx` and `pronto_medida` are ignored outside their wait states.
- `seletor` and `posicao` hold their values between updates. Character content is produced by the external mux: 0–2 angle digits, 3 ',', 4–6 distance digits, 7 '.'.

## Timing
- `ligar` high at INICIAL → first `medir` after 1 + 1 + TIMER + 1 cycles (INICIAL, PREPARA, POSICIONA×TIMER, MEDE).
- `pronto_medida` → `partida_tx` 1 cycle later.
- `pronto_tx` → next `partida_tx` 2 cycles later (PROX_CHAR, TRANSMITE).
- Last `pronto_tx` → `posicao` updated 1 cycle later; next dwell starts the cycle after.
- `medir` → `erro_medida` after TIMEOUT+1 cycles if no `pronto_medida` arrives.
- `reset` asserted in any state → INICIAL, counters 0, direction=up, all outputs 0 on the next edge.
- Counter widths: `$clog2(TIMER)` and `$clog2(TIMEOUT)`, no wrap beyond terminal count.

## Structure
- Shared package `sonar_pkg` holds:
  - state encodings (4-bit localparams);
  - `NUM_POSICOES`=8 and `NUM_CHARS`=8;
  - frame character index constants.
- One sub-module, `contador_m` (parameterised modulo counter with clear, enable and terminal-count flag), instantiated for both the dwell timer and the timeout counter.
- The position/direction and `seletor` counters are kept inline.

## Test plan
All scenarios use TIMER=250 and TIMEOUT=100.
- Reset held 3 cycles, then `ligar`=1 → `db_estado` 0→1→2; `medir` pulses exactly 253 cycles after `ligar`; `posicao`=0.
- `pronto_medida` 20 cycles after `medir`, UART model answering `pronto_tx` 10 cycles after each `partida_tx` → exactly 8 `partida_tx` pulses with `seletor` 0..7 in order; then `posicao`=1.
- 16 full positions → `posicao` sequence 0..7,6..0,1; `fim_posicao` pulses on reaching 7 and on reaching 0.
- No `pronto_medida` → `erro_medida` pulse 101 cycles after `medir`; no `partida_tx`; `posicao` advances.
- `pronto_medida` in the same cycle as timeout terminal count → no `erro_medida`; frame transmitted.
- `ligar` dropped during AGUARDA_TX at `seletor`=3 → remaining 4 characters sent, then INICIAL. Separately, `reset` at `seletor`=5 → INICIAL next cycle with all outputs 0.
